// File: rtl/mul_iter_pkg.sv
// mul_iter_pkg: shared types for the iterative RV32M/RV64M multiplier.
// Register bundle is sized for the widest XLEN; narrower builds leave upper bits zero.
package mul_iter_pkg;

  localparam int XMAX  = 64;
  localparam int ACC_W = 2 * XMAX;
  localparam int CNT_W = 7;

  typedef struct packed {
    logic muls;
    logic mulh;
    logic mulhsu;
    logic mulhu;
  } mul_op_type;

  localparam mul_op_type OP_MULS   = mul_op_type'(4'b1000);
  localparam mul_op_type OP_MULH   = mul_op_type'(4'b0100);
  localparam mul_op_type OP_MULHSU = mul_op_type'(4'b0010);
  localparam mul_op_type OP_MULHU  = mul_op_type'(4'b0001);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mul_iter_state_type;

  typedef struct packed {
    mul_iter_state_type state;
    logic [CNT_W-1:0]   counter;
    mul_op_type         op;
    logic [XMAX-1:0]    op1_mag;
    logic [XMAX-1:0]    op2_mag;
    logic [ACC_W-1:0]   acc;
    logic               negate;
  } mul_iter_reg_type;

  localparam mul_iter_reg_type init_mul_iter_reg = '{
    state:   IDLE,
    counter: '0,
    op:      '0,
    op1_mag: '0,
    op2_mag: '0,
    acc:     '0,
    negate:  1'b0
  };

endpackage

// File: rtl/lzc_chunk.sv
// lzc_chunk: counts leading all-zero STEP_BITS-wide chunks of a value.
// An all-zero value yields XLEN/STEP_BITS.
module lzc_chunk
  import mul_iter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 2
) (
  input  logic [XLEN-1:0]  val_i,
  output logic [CNT_W-1:0] count_o
);

  localparam int NCH = XLEN / STEP_BITS;

  logic found;

  always_comb begin
    count_o = '0;
    found   = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (!found) begin
        if (val_i[i*STEP_BITS +: STEP_BITS] == '0)
          count_o = count_o + CNT_W'(1);
        else
          found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul_iter.sv
// mul_iter: iterative MUL/MULH/MULHSU/MULHU unit, MSB-first radix-2^STEP_BITS.
// Operands become magnitudes on entry; the sign is reapplied in DONE.
module mul_iter
  import mul_iter_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 2,
  parameter int EARLY_OUT = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  mul_op_type      op,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic            flush,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] result
);

  localparam int NCH = XLEN / STEP_BITS;

  if (!(STEP_BITS == 1 || STEP_BITS == 2 ||
        STEP_BITS == 4 || STEP_BITS == 8) ||
      (XLEN % STEP_BITS) != 0 ||
      !(XLEN == 32 || XLEN == 64)) begin : g_bad_cfg
    $error("mul_iter: unsupported XLEN/STEP_BITS");
  end

  mul_iter_reg_type r;
  mul_iter_reg_type rin;
  mul_iter_reg_type v;

  logic                 sign1;
  logic                 sign2;
  logic [XLEN-1:0]      mag1;
  logic [XLEN-1:0]      mag2;
  logic [CNT_W-1:0]     lz;
  logic [CNT_W-1:0]     n;
  logic [31:0]          sh;
  logic [STEP_BITS-1:0] chunk;
  logic [ACC_W-1:0]     fin;
  logic [31:0]          shamt;

  if (EARLY_OUT != 0) begin : g_lzc
    lzc_chunk #(
      .XLEN      (XLEN),
      .STEP_BITS (STEP_BITS)
    ) u_lzc (
      .val_i   (mag1),
      .count_o (lz)
    );
  end else begin : g_no_lzc
    assign lz = '0;
  end

  always_comb begin
    v     = r;
    sign1 = (op.muls | op.mulh | op.mulhsu) & rdata1[XLEN-1];
    sign2 = (op.muls | op.mulh) & rdata2[XLEN-1];
    mag1  = sign1 ? -rdata1 : rdata1;
    mag2  = sign2 ? -rdata2 : rdata2;
    n     = CNT_W'(NCH) - lz;
    sh    = (32'(r.counter) - 32'd1) * 32'(STEP_BITS);
    chunk = STEP_BITS'(r.op1_mag >> sh);
    unique case (r.state)
      IDLE: begin
        if (enable && !flush) begin
          v.op      = op;
          v.op1_mag = XMAX'(mag1);
          v.op2_mag = XMAX'(mag2);
          v.negate  = sign1 ^ sign2;
          v.acc     = '0;
          v.counter = n;
          v.state   = (n == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        v.acc = (r.acc << STEP_BITS) +
                (ACC_W'(chunk) * ACC_W'(r.op2_mag));
        v.counter = r.counter - CNT_W'(1);
        if (r.counter == CNT_W'(1))
          v.state = DONE;
      end
      DONE: v.state = IDLE;
      default: v = init_mul_iter_reg;
    endcase
    if (flush && r.state != IDLE)
      v = init_mul_iter_reg;
    rin = v;
  end

  always_ff @(posedge clock) begin
    if (reset)
      r <= init_mul_iter_reg;
    else
      r <= rin;
  end

  // Low half only for MUL; every high-half op (and a stray empty op) takes the top.
  always_comb begin
    fin    = r.negate ? -r.acc : r.acc;
    shamt  = (r.op == OP_MULS) ? 32'd0 : 32'(XLEN);
    busy   = (r.state != IDLE);
    ready  = (r.state == DONE) && !flush && !reset;
    result = ready ? XLEN'(fin >> shamt) : '0;
  end

endmodule

// File: tb/tb_mul_iter.sv
// tb_mul_iter: drives an early-out and a fixed-latency 32/2 multiplier
// with directed and random ops, scoreboarding result and latency.
module tb_mul_iter;
  import mul_iter_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        en_e;
  logic        en_f;
  logic        flush;
  mul_op_type  op;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        busy_e;
  logic        ready_e;
  logic [31:0] result_e;
  logic        busy_f;
  logic        ready_f;
  logic [31:0] result_f;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_e[$];
  exp_t sb_f[$];

  always #5 clock = ~clock;

  mul_iter #(.XLEN(32), .STEP_BITS(2), .EARLY_OUT(1)) u_eo (
    .clock  (clock),
    .reset  (reset),
    .enable (en_e),
    .op     (op),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .flush  (flush),
    .busy   (busy_e),
    .ready  (ready_e),
    .result (result_e)
  );

  mul_iter #(.XLEN(32), .STEP_BITS(2), .EARLY_OUT(0)) u_fx (
    .clock  (clock),
    .reset  (reset),
    .enable (en_f),
    .op     (op),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .flush  (flush),
    .busy   (busy_f),
    .ready  (ready_f),
    .result (result_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input mul_op_type o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic        s1;
    logic        s2;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    s1 = o.muls | o.mulh | o.mulhsu;
    s2 = o.muls | o.mulh;
    ea = {{32{s1 & a[31]}}, a};
    eb = {{32{s2 & b[31]}}, b};
    p  = ea * eb;
    return o.muls ? p[31:0] : p[63:32];
  endfunction

  function automatic int lat_eo(input mul_op_type o, input logic [31:0] a);
    logic [31:0] mag;
    int          bl;
    mag = ((o.muls | o.mulh | o.mulhsu) && a[31]) ? (~a + 32'd1) : a;
    bl  = 0;
    for (int i = 0; i < 32; i++)
      if (mag[i]) bl = i + 1;
    return (bl + 1) / 2 + 1;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 15));
      1:       return $urandom;
      2:       return 32'h8000_0000;
      default: return 32'hFFFF_FFFF >> $urandom_range(0, 31);
    endcase
  endfunction

  function automatic mul_op_type rnd_op();
    case ($urandom_range(0, 3))
      0:       return OP_MULS;
      1:       return OP_MULH;
      2:       return OP_MULHSU;
      default: return OP_MULHU;
    endcase
  endfunction

  // Call at a negedge with both units idle; returns at a negedge, both idle.
  task automatic do_op(input mul_op_type o, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    exp_t ee;
    exp_t ef;
    exp_t g;
    bit   got_e;
    bit   got_f;
    int   nb;
    ee.res = ref_mul(o, a, b);
    ee.lat = lat_eo(o, a);
    ef.res = ee.res;
    ef.lat = 17;
    sb_e.push_back(ee);
    sb_f.push_back(ef);
    op     = o;
    rdata1 = a;
    rdata2 = b;
    en_e   = 1'b1;
    en_f   = 1'b1;
    @(negedge clock);
    en_e  = 1'b0;
    en_f  = 1'b0;
    got_e = 1'b0;
    got_f = 1'b0;
    nb    = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy_f) nb++;
      if (ready_e && !got_e) begin
        g = sb_e.pop_front();
        chk({tag, " res_e"}, result_e, g.res);
        chk({tag, " lat_e"}, 32'(k), 32'(g.lat));
        got_e = 1'b1;
      end
      if (ready_f && !got_f) begin
        g = sb_f.pop_front();
        chk({tag, " res_f"}, result_f, g.res);
        chk({tag, " lat_f"}, 32'(k), 32'(g.lat));
        got_f = 1'b1;
      end
      if (got_e && got_f) break;
      @(negedge clock);
    end
    chk({tag, " done_e"}, 32'(got_e), 32'd1);
    chk({tag, " done_f"}, 32'(got_f), 32'd1);
    chk({tag, " busy_f_cycles"}, 32'(nb), 32'd17);
    @(negedge clock);
    chk({tag, " idle_result"}, result_e | result_f, 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    en_e   = 1'b0;
    en_f   = 1'b0;
    flush  = 1'b0;
    op     = OP_MULS;
    rdata1 = '0;
    rdata2 = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_flags", {28'd0, busy_e, busy_f, ready_e, ready_f}, 32'd0);
    chk("reset_res", result_e | result_f, 32'd0);

    do_op(OP_MULS,   32'd7,        32'hFFFF_FFFD, "muls_7x-3");
    do_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, "mulh_min");
    do_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    do_op(OP_MULS,   32'd3,        32'd5,         "muls_3x5");
    do_op(OP_MULS,   32'd0,        32'h1234_5678, "muls_zero");
    do_op(OP_MULH,   32'h8000_0000, 32'd1,        "mulh_min_1");

    // enable held through CALC and DONE: no recapture, restart from IDLE
    op     = OP_MULS;
    rdata1 = 32'd3;
    rdata2 = 32'd5;
    en_e   = 1'b1;
    @(negedge clock);
    rdata1 = 32'd2;
    rdata2 = 32'd9;
    chk("b2b_k1", {30'd0, busy_e, ready_e}, 32'd2);
    @(negedge clock);
    chk("b2b_k2_rdy", 32'(ready_e), 32'd1);
    chk("b2b_k2_res", result_e, 32'd15);
    @(negedge clock);
    chk("b2b_k3_idle", 32'(busy_e), 32'd0);
    @(negedge clock);
    en_e = 1'b0;
    chk("b2b_k4", {30'd0, busy_e, ready_e}, 32'd2);
    @(negedge clock);
    chk("b2b_k5_rdy", 32'(ready_e), 32'd1);
    chk("b2b_k5_res", result_e, 32'd18);
    @(negedge clock);

    // flush at T+5 of a full-length op
    op     = OP_MULHU;
    rdata1 = 32'hFFFF_FFFF;
    rdata2 = 32'd3;
    en_e   = 1'b1;
    en_f   = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      en_e = 1'b0;
      en_f = 1'b0;
      chk("flush_pre", {28'd0, busy_e, busy_f, ready_e, ready_f}, 32'hC);
      if (k == 5) flush = 1'b1;
    end
    @(negedge clock);
    flush = 1'b0;
    chk("flush_post", {28'd0, busy_e, busy_f, ready_e, ready_f}, 32'd0);
    do_op(OP_MULS, 32'd7, 32'd6, "after_flush");

    // synchronous reset mid-operation
    op     = OP_MULHU;
    rdata1 = 32'hFFFF_FFFF;
    rdata2 = 32'd9;
    en_e   = 1'b1;
    en_f   = 1'b1;
    @(negedge clock);
    en_e = 1'b0;
    en_f = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_flags", {28'd0, busy_e, busy_f, ready_e, ready_f}, 32'd0);
    chk("midrst_res", result_e | result_f, 32'd0);
    do_op(OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, "after_reset");

    for (int i = 0; i < 200; i++)
      do_op(rnd_op(), rnd_opnd(), rnd_opnd(), "rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
